if_fetch_unit: RTL and testbench

//  Instruction-fetch front end: owns the fetch PC, issues in-order requests to

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
//   XLEN          : datapath width
//   NOP_INST      : bubble instruction (addi x0,x0,0)
//   fetch_entry_t : {pc, inst} pair carried through the fetch queues
//   rsp_e         : what happens to a memory response this cycle
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RSP_NONE,   // no response, or a response with nothing in flight
        RSP_DROP,   // response belongs to a fetch discarded by redirect
        RSP_PUSH    // response belongs to the oldest live fetch
    } rsp_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush and occupancy count.
//   clk, rst : clock, synchronous active-high reset
//   flush    : empty the FIFO (same cycle priority as rst)
//   push     : write wdata (accepted when not full, or full with a pop)
//   pop      : discard head (ignored when empty)
//   rdata    : head entry, read directly from storage
//   count    : number of stored entries
//   empty    : count == 0
//   full     : count == DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests
// over req/gnt/rvalid, pairs each returned word with its PC and presents the
// oldest buffered instruction to the IF/ID register.
//   clk, rst              : clock, synchronous active-high reset
//   imem_req/addr/gnt     : request handshake (req&gnt = issue)
//   imem_rvalid/rdata     : in-order responses
//   stall                 : IF/ID not accepting; holds the presented word
//   redirect/redirect_pc  : discard all fetches and restart at redirect_pc
//   valid_IF/pc_curr_IF/inst_IF : presented instruction (0 / NOP when empty)
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid_IF,
    output logic [31:0] pc_curr_IF,
    output logic [31:0] inst_IF
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]    fetch_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop;
    logic [CW-1:0]  drop_after;
    logic [CW-1:0]  out_after;
    logic [CW-1:0]  buf_count;
    logic [CW-1:0]  pcq_count;
    logic [CW+1:0]  occupancy;
    rsp_e           rsp;
    logic           rsp_push;
    logic           issue;
    logic           pop_out;
    logic           pcq_empty;
    logic           pcq_full;
    logic           buf_empty;
    logic           buf_full;
    fetch_entry_t   pcq_wdata;
    fetch_entry_t   pcq_head;
    fetch_entry_t   buf_wdata;
    fetch_entry_t   buf_head;
    logic           unused_bits;

    always_comb begin
        rsp = RSP_NONE;
        if (imem_rvalid) begin
            if (drop != '0)             rsp = RSP_DROP;
            else if (outstanding != '0) rsp = RSP_PUSH;
        end
    end

    assign rsp_push   = (rsp == RSP_PUSH);
    assign drop_after = drop - CW'(rsp == RSP_DROP);
    assign out_after  = outstanding - CW'(rsp_push);

    assign valid_IF   = !buf_empty;
    assign pop_out    = valid_IF && !stall && !redirect;
    assign pc_curr_IF = valid_IF ? buf_head.pc   : '0;
    assign inst_IF    = valid_IF ? buf_head.inst : NOP_INST;

    // The slot freed by this cycle's pop is credited immediately: the request
    // issued now cannot return before next cycle, which sustains one
    // instruction per cycle with DEPTH=2 and latency-1 memory.
    assign occupancy = (CW+2)'(outstanding) + (CW+2)'(drop)
                     + (CW+2)'(buf_count) - (CW+2)'(pop_out);
    assign imem_req  = !rst && !redirect && (occupancy < (CW+2)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;

    assign pcq_wdata = '{pc: fetch_pc, inst: '0};
    assign buf_wdata = '{pc: pcq_head.pc, inst: imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (issue),
        .wdata (pcq_wdata),
        .pop   (rsp_push),
        .rdata (pcq_head),
        .count (pcq_count),
        .empty (pcq_empty),
        .full  (pcq_full)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_ret_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (rsp_push),
        .wdata (buf_wdata),
        .pop   (pop_out),
        .rdata (buf_head),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            outstanding <= '0;
            // Every response still owed by memory is now garbage, including
            // ones already marked for dropping by an earlier redirect.
            drop        <= drop_after + out_after;
        end else begin
            drop        <= drop_after;
            outstanding <= out_after + CW'(issue);
            if (issue) fetch_pc <= fetch_pc + 32'd4;
        end
    end

    assign unused_bits = ^{pcq_head.inst, pcq_count, pcq_empty, pcq_full,
                           buf_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a memory model answers granted fetches
// in order with a word derived from the address; every grant pushes the
// expected {pc, inst} and a monitor compares each presented instruction.
module tb_if_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_EXP  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic        stale;
    } mreq_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid_IF;
    logic [31:0] pc_curr_IF;
    logic [31:0] inst_IF;

    int errors = 0;
    int checks = 0;
    int consumed = 0;
    int cyc = 0;
    bit directed1 = 1'b0;
    bit rst_prev = 1'b0;

    int gnt_pct = 100;
    int rv_pct = 100;
    int stall_pct = 0;
    int redir_pct = 0;
    bit redir_fixed = 1'b0;
    logic [31:0] redir_val = '0;

    logic [31:0]  model_pc = RESET_PC;
    fetch_entry_t sb[$];
    mreq_t        mq[$];

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP_EXP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .valid_IF    (valid_IF),
        .pc_curr_IF  (pc_curr_IF),
        .inst_IF     (inst_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (valid_IF) break;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s: got no valid_IF within 50 cycles, expected pc %h", name, exp_pc);
        end else begin
            check(name, pc_curr_IF, exp_pc);
        end
    endtask

    // Driver: memory model and random control inputs, applied just after posedge.
    initial begin
        bit any_stale;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata = $urandom;
            if (mq.size() > 0 &&
                (($urandom_range(99) < rv_pct) || (mq[0].stale && !rst))) begin
                imem_rvalid = 1'b1;
                imem_rdata = inst_of(mq[0].addr);
                mq.delete(0);
            end
            any_stale = 1'b0;
            foreach (mq[i]) if (mq[i].stale) any_stale = 1'b1;
            imem_gnt = !any_stale && ($urandom_range(99) < gnt_pct);
            stall = ($urandom_range(99) < stall_pct);
            redirect = ($urandom_range(99) < redir_pct);
            if (redir_fixed)
                redirect_pc = redir_val;
            else if ($urandom_range(7) == 0)
                redirect_pc = 32'hFFFF_FFF4 | 32'($urandom_range(3));
            else
                redirect_pc = $urandom;
        end
    end

    // Stimulus bookkeeping: grants push expected entries, redirect/reset flush.
    initial begin
        fetch_entry_t e;
        mreq_t m;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                sb.delete();
                model_pc = RESET_PC;
                foreach (mq[i]) mq[i].stale = 1'b1;
            end else if (redirect) begin
                check("req_low_on_redirect", 32'(imem_req), 32'd0);
                sb.delete();
                model_pc = redirect_pc & ~32'd3;
            end else if (imem_req && imem_gnt) begin
                check("issue_addr", imem_addr, model_pc);
                e.pc = model_pc;
                e.inst = inst_of(model_pc);
                sb.push_back(e);
                m.addr = imem_addr;
                m.stale = 1'b0;
                mq.push_back(m);
                model_pc = model_pc + 32'd4;
            end
        end
    end

    // Monitor: compares the presented instruction against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rst_prev) begin
                    check("rst_req", 32'(imem_req), 32'd0);
                    check("rst_valid", 32'(valid_IF), 32'd0);
                    check("rst_pc", pc_curr_IF, 32'd0);
                    check("rst_inst", inst_IF, NOP_EXP);
                end
                cyc = 0;
            end else begin
                if (valid_IF) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got pc %h inst %h, none expected",
                                 pc_curr_IF, inst_IF);
                    end else begin
                        check("out_pc", pc_curr_IF, sb[0].pc);
                        check("out_inst", inst_IF, sb[0].inst);
                        if (!stall && !redirect) begin
                            sb.delete(0);
                            consumed++;
                        end
                    end
                end else begin
                    check("idle_pc", pc_curr_IF, 32'd0);
                    check("idle_inst", inst_IF, NOP_EXP);
                end
                if (directed1) check("startup_valid", 32'(valid_IF), 32'(cyc >= 2));
                cyc++;
            end
            rst_prev = rst;
        end
    end

    initial begin
        rst = 1'b1;
        directed1 = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Streaming from reset: valid from the third cycle, one per cycle.
        repeat (12) @(posedge clk);
        directed1 = 1'b0;

        // Stall: credits run out, request drops, outputs held.
        stall_pct = 100;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_credit_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        stall_pct = 0;
        repeat (4) @(posedge clk);

        // No grant: request held at the same address.
        gnt_pct = 0;
        repeat (3) begin
            @(negedge clk);
            check("gnt_hold_req", 32'(imem_req), 32'd1);
            check("gnt_hold_addr", imem_addr, model_pc);
            @(posedge clk);
        end
        gnt_pct = 100;
        repeat (4) @(posedge clk);

        // Redirect with two fetches in flight.
        rv_pct = 0;
        repeat (4) @(posedge clk);
        redir_fixed = 1'b1;
        redir_val = 32'h0000_0100;
        redir_pct = 100;
        @(posedge clk);
        redir_pct = 0;
        rv_pct = 100;
        wait_valid("redirect_target", 32'h0000_0100);

        // Redirect together with stall and a returning word.
        @(posedge clk);
        rv_pct = 0;
        repeat (2) @(posedge clk);
        stall_pct = 100;
        rv_pct = 100;
        redir_val = 32'h0000_0203;
        redir_pct = 100;
        @(posedge clk);
        stall_pct = 0;
        redir_pct = 0;
        wait_valid("redirect_stall_target", 32'h0000_0200);

        // Reset with fetches in flight; their late responses must be ignored.
        @(posedge clk);
        rv_pct = 0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        rv_pct = 100;
        wait_valid("reset_restart", RESET_PC);

        // Randomised traffic, including one mid-stream reset.
        redir_fixed = 1'b0;
        for (int seg = 0; seg < 6; seg++) begin
            @(posedge clk);
            gnt_pct = int'($urandom_range(30, 100));
            rv_pct = int'($urandom_range(30, 100));
            stall_pct = int'($urandom_range(0, 60));
            redir_pct = int'($urandom_range(0, 8));
            repeat (200) @(posedge clk);
            if (seg == 2) begin
                #2 rst = 1'b1;
                repeat (2) @(posedge clk);
                #2 rst = 1'b0;
            end
        end

        @(posedge clk);
        gnt_pct = 100;
        rv_pct = 100;
        stall_pct = 0;
        redir_pct = 0;
        repeat (30) @(posedge clk);
        check("progress", 32'(consumed >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
